// File: rtl/branch_redirect_unit_if.sv
// EXU-to-IFU redirect bus: resolved control-transfer input, redirect request and branch statistics.
// Latency: none, this file only bundles wires.
// Backpressure: in_valid/in_ready towards the EXU, redir_valid/redir_ready towards the IFU.
//
// Ports, slave view (the redirect unit):
//   in_valid, in_op, in_pc, in_imm, in_rs1, Compare_Result, redir_ready : inputs
//   in_ready, redir_valid, redir_pc, flush, misalign, br_total, br_taken : outputs
interface branch_redirect_unit_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_imm;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  Compare_Result;
  logic             redir_valid;
  logic             redir_ready;
  logic [XLEN-1:0]  redir_pc;
  logic             flush;
  logic             misalign;
  logic [CNT_W-1:0] br_total;
  logic [CNT_W-1:0] br_taken;

  modport slave (
    input  in_valid, in_op, in_pc, in_imm, in_rs1, Compare_Result, redir_ready,
    output in_ready, redir_valid, redir_pc, flush, misalign, br_total, br_taken
  );

  modport master (
    output in_valid, in_op, in_pc, in_imm, in_rs1, Compare_Result, redir_ready,
    input  in_ready, redir_valid, redir_pc, flush, misalign, br_total, br_taken
  );
endinterface

// File: rtl/branch_redirect_unit.sv
// Turns a resolved taken branch/jump into a held IFU redirect followed by a FLUSH_CYCLES flush window.
// Latency: accept edge to redir_valid 1 cycle; misalign pulses the cycle after accept.
// Backpressure: in_ready only in IDLE; redirect held until redir_ready is sampled high.
//
// Ports: clk, rst_n (async active-low); bus (slave modport of branch_redirect_unit_if)
//   carrying the EXU handshake, the IFU redirect handshake, flush/misalign and the
//   saturating br_total/br_taken counters.
module branch_redirect_unit #(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_redirect_unit_if.slave bus
);

  localparam logic [1:0] OP_BR   = 2'd1;
  localparam logic [1:0] OP_JAL  = 2'd2;
  localparam logic [1:0] OP_JALR = 2'd3;

  localparam bit         HAS_FLUSH  = (FLUSH_CYCLES > 0);
  localparam logic [3:0] FLUSH_LOAD = HAS_FLUSH ? 4'(FLUSH_CYCLES - 1) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] br_total_q, br_total_d;
  logic [CNT_W-1:0] br_taken_q, br_taken_d;

  logic             accept;
  logic             taken;
  logic [XLEN-1:0]  base;
  logic [XLEN-1:0]  target;

  // Only the LSB of the compare result carries the condition.
  logic unused_cmp;
  assign unused_cmp = ^bus.Compare_Result[XLEN-1:1];

  assign accept = bus.in_valid && (state_q == IDLE);

  always_comb begin
    taken = 1'b0;
    case (bus.in_op)
      OP_BR:   taken = bus.Compare_Result[0];
      OP_JAL:  taken = 1'b1;
      OP_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // JALR adds to rs1 and drops bit 0; branches and JAL add to the PC.
  always_comb begin
    base   = (bus.in_op == OP_JALR) ? bus.in_rs1 : bus.in_pc;
    target = base + bus.in_imm;
    if (bus.in_op == OP_JALR) target[0] = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    redir_pc_d  = redir_pc_q;
    flush_cnt_d = flush_cnt_q;
    misalign_d  = 1'b0;
    br_total_d  = br_total_q;
    br_taken_d  = br_taken_q;

    case (state_q)
      IDLE: begin
        if (accept && taken) begin
          // A misaligned target is reported but never redirected.
          if (target[1]) begin
            misalign_d = 1'b1;
          end else begin
            state_d    = REDIRECT;
            redir_pc_d = target;
          end
        end
      end
      REDIRECT: begin
        if (bus.redir_ready) begin
          if (HAS_FLUSH) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Statistics saturate instead of wrapping; misaligned taken branches still count.
    if (accept && (bus.in_op == OP_BR)) begin
      if (br_total_q != '1) br_total_d = br_total_q + CNT_ONE;
      if (taken && (br_taken_q != '1)) br_taken_d = br_taken_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      redir_pc_q  <= '0;
      flush_cnt_q <= 4'd0;
      misalign_q  <= 1'b0;
      br_total_q  <= '0;
      br_taken_q  <= '0;
    end else begin
      state_q     <= state_d;
      redir_pc_q  <= redir_pc_d;
      flush_cnt_q <= flush_cnt_d;
      misalign_q  <= misalign_d;
      br_total_q  <= br_total_d;
      br_taken_q  <= br_taken_d;
    end
  end

  // Handshake and flush outputs decode the registered state only.
  assign bus.in_ready    = (state_q == IDLE);
  assign bus.redir_valid = (state_q == REDIRECT);
  assign bus.flush       = (state_q == FLUSH);
  assign bus.redir_pc    = redir_pc_q;
  assign bus.misalign    = misalign_q;
  assign bus.br_total    = br_total_q;
  assign bus.br_taken    = br_taken_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Self-checking bench for branch_redirect_unit: directed scenarios plus randomized traffic.
// Latency: one modelled clock edge per step; outputs sampled on the falling edge.
// Backpressure: redir_ready driven randomly or held low to stretch redirects.
module tb_branch_redirect_unit;

  localparam int XLEN    = 64;
  localparam int FLUSH   = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  branch_redirect_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) b ();

  branch_redirect_unit #(
    .XLEN(XLEN),
    .FLUSH_CYCLES(FLUSH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(b.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a pending-redirect flag, remaining flush cycles and plain counters.
  bit          m_redir;
  logic [63:0] m_pc;
  int          m_flush_left;
  bit          m_mis;
  int          m_tot;
  int          m_tkn;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return !m_redir && (m_flush_left == 0);
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_redir      = 1'b0;
    m_pc         = '0;
    m_flush_left = 0;
    m_mis        = 1'b0;
    m_tot        = 0;
    m_tkn        = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit          rdy;
    bit          tk;
    logic [63:0] tgt;
    rdy   = m_ready();
    m_mis = 1'b0;
    if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (m_redir && b.redir_ready) begin
      m_redir      = 1'b0;
      m_flush_left = FLUSH;
    end
    if (b.in_valid && rdy) begin
      tk = (b.in_op == 2'd1) ? b.Compare_Result[0] : (b.in_op != 2'd0);
      if (b.in_op == 2'd3) tgt = (b.in_rs1 + b.in_imm) & ~64'h1;
      else                 tgt = b.in_pc + b.in_imm;
      if (b.in_op == 2'd1) begin
        m_tot = sat_inc(m_tot);
        if (tk) m_tkn = sat_inc(m_tkn);
      end
      if (tk) begin
        if (tgt[1]) m_mis = 1'b1;
        else begin
          m_redir = 1'b1;
          m_pc    = tgt;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_val("in_ready",    64'(b.in_ready),    64'(m_ready()));
    check_val("redir_valid", 64'(b.redir_valid), 64'(m_redir));
    check_val("flush",       64'(b.flush),       64'(m_flush_left > 0));
    check_val("misalign",    64'(b.misalign),    64'(m_mis));
    if (m_redir) check_val("redir_pc", b.redir_pc, m_pc);
    check_val("br_total",    64'(b.br_total),    64'(m_tot));
    check_val("br_taken",    64'(b.br_taken),    64'(m_tkn));
  endtask

  // Entered and left on a falling edge.
  task automatic step(input bit v, input logic [1:0] op, input logic [63:0] pc,
                      input logic [63:0] imm, input logic [63:0] rs1,
                      input logic [63:0] cmp, input bit rr);
    b.in_valid       = v;
    b.in_op          = op;
    b.in_pc          = pc;
    b.in_imm         = imm;
    b.in_rs1         = rs1;
    b.Compare_Result = cmp;
    b.redir_ready    = rr;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input bit rr);
    step(1'b0, 2'd0, '0, '0, '0, '0, rr);
  endtask

  task automatic apply_reset(input string tag);
    b.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val({tag, "_in_ready"},    64'(b.in_ready),    64'd1);
    check_val({tag, "_redir_valid"}, 64'(b.redir_valid), 64'd0);
    check_val({tag, "_redir_pc"},    b.redir_pc,         64'd0);
    check_val({tag, "_flush"},       64'(b.flush),       64'd0);
    check_val({tag, "_misalign"},    64'(b.misalign),    64'd0);
    check_val({tag, "_br_total"},    64'(b.br_total),    64'd0);
    check_val({tag, "_br_taken"},    64'(b.br_taken),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    logic [63:0] imm;
    logic [63:0] cmp;
    b.in_valid       = 1'b0;
    b.in_op          = 2'd0;
    b.in_pc          = '0;
    b.in_imm         = '0;
    b.in_rs1         = '0;
    b.Compare_Result = '0;
    b.redir_ready    = 1'b0;
    model_reset();

    #2;
    @(negedge clk);
    apply_reset("rst0");

    // Back-to-back not-taken branches.
    for (int i = 0; i < 5; i++) step(1'b1, 2'd1, 64'h100 + 64'(4 * i), 64'h40, '0, '0, 1'b1);
    check_val("nt_total",   64'(b.br_total),    64'd5);
    check_val("nt_taken",   64'(b.br_taken),    64'd0);
    check_val("nt_ready",   64'(b.in_ready),    64'd1);

    // Taken branch with negative offset.
    step(1'b1, 2'd1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFF0, '0, ONES, 1'b1);
    check_val("tb_valid", 64'(b.redir_valid), 64'd1);
    check_val("tb_pc",    b.redir_pc,         64'h7FFF_FFF0);
    idle(1'b1);
    check_val("tb_flush1", 64'(b.flush), 64'd1);
    idle(1'b1);
    check_val("tb_flush2", 64'(b.flush), 64'd1);
    idle(1'b1);
    check_val("tb_ready",  64'(b.in_ready), 64'd1);
    check_val("tb_flush0", 64'(b.flush),    64'd0);

    // JAL held under IFU backpressure; new requests must be ignored meanwhile.
    step(1'b1, 2'd2, 64'h1000, 64'h100, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'd2, 64'h2000, 64'h8, '0, '0, 1'b0);
    check_val("bp_pc",    b.redir_pc,         64'h1100);
    check_val("bp_valid", 64'(b.redir_valid), 64'd1);
    step(1'b1, 2'd2, 64'h2000, 64'h8, '0, '0, 1'b1);
    check_val("bp_flush", 64'(b.flush), 64'd1);
    idle(1'b0);
    idle(1'b0);

    // JALR: misaligned target, then aligned one.
    step(1'b1, 2'd3, 64'h0, 64'h4, 64'h8000_0103, '0, 1'b1);
    check_val("jalr_mis",   64'(b.misalign),    64'd1);
    check_val("jalr_ready", 64'(b.in_ready),    64'd1);
    check_val("jalr_nored", 64'(b.redir_valid), 64'd0);
    step(1'b1, 2'd3, 64'h0, 64'h4, 64'h8000_0101, '0, 1'b1);
    check_val("jalr_pc",    b.redir_pc,      64'h8000_0104);
    check_val("jalr_mis0",  64'(b.misalign), 64'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Target wraps modulo 2^64.
    step(1'b1, 2'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, '0, '0, 1'b1);
    check_val("wrap_pc", b.redir_pc, 64'h4);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Counter saturation with 20 taken branches.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 2'd1, 64'h4000, 64'h40, '0, ONES, 1'b1);
      for (int j = 0; j < 3; j++) idle(1'b1);
    end
    check_val("sat_total", 64'(b.br_total), 64'd15);
    check_val("sat_taken", 64'(b.br_taken), 64'd15);

    // Reset while a redirect is pending.
    step(1'b1, 2'd2, 64'h3000, 64'h10, '0, '0, 1'b0);
    check_val("mid_valid", 64'(b.redir_valid), 64'd1);
    apply_reset("rst_mid");
    idle(1'b0);
    check_val("mid_ready", 64'(b.in_ready), 64'd1);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      if ((c % 700) == 699) apply_reset("rst_rnd");
      case ($urandom_range(0, 3))
        0:       cmp = '0;
        1:       cmp = ONES;
        default: cmp = {$urandom, $urandom};
      endcase
      imm = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) imm = imm & 64'h0000_0000_0000_0FFE;
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           {$urandom, $urandom}, imm, {$urandom, $urandom}, cmp,
           $urandom_range(0, 9) < 6);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Sequential consumer of the ALU compare result. It accepts one resolved control-transfer instruction per handshake from the EXU and turns a taken branch or jump into a held redirect request to the IFU, followed by a programmable pipeline flush window. It sits between the EXU compare/adder path and the IFU PC mux. The front end predicts statically not-taken, so every taken transfer redirects.

## Interface
- XLEN, 64, datapath width
- FLUSH_CYCLES, 2, flush-pulse length after a redirect is accepted (0..15)
- CNT_W, 32, width of statistics counters

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  EXU has a resolved instruction
- in_ready  out  1  unit can accept (IDLE only)
- in_op  in  2  0 none, 1 conditional branch, 2 JAL, 3 JALR
- in_pc  in  XLEN  instruction PC
- in_imm  in  XLEN  sign-extended immediate
- in_rs1  in  XLEN  rs1 value (JALR base)
- Compare_Result  in  XLEN  compare unit output, all-ones = condition true, zero = false
- redir_valid  out  1  redirect request to IFU
- redir_ready  in  1  IFU accepts redirect
- redir_pc  out  XLEN  redirect target
- flush  out  1  squash younger IF/ID stages
- misalign  out  1  one-cycle pulse: taken target not 4-byte aligned
- br_total  out  CNT_W  accepted op 1 instructions
- br_taken  out  CNT_W  accepted op 1 instructions that were taken

## Operation
- Handshake: transfer when in_valid && in_ready on a rising edge. in_ready = (state == IDLE), combinational from state only.
- Taken: op 1 → Compare_Result[0]. Bits [63:1] are ignored. Op 2 and op 3 are always taken. Op 0 is accepted and has no effect.
- Target:
  - op 1 and op 2: in_pc + in_imm, modulo 2^XLEN.
  - op 3: (in_rs1 + in_imm) & ~1, modulo 2^XLEN.
- Misaligned: a taken target with bit[1] set pulses misalign for one cycle. No redirect is issued and the FSM stays in IDLE.
- States:
  - IDLE → REDIRECT on accepting a taken, aligned instruction. redir_pc is registered at the accept edge.
  - REDIRECT: redir_valid=1, redir_pc held stable.
    - redir_ready=1 with FLUSH_CYCLES>0 → FLUSH, counter loaded with FLUSH_CYCLES-1.
    - redir_ready=1 with FLUSH_CYCLES==0 → IDLE.
    - Otherwise stay in REDIRECT.
  - FLUSH: flush=1. Counter==0 → IDLE, else counter decrements.
- Counters update at the accept edge only and saturate at all-ones with no wrap. br_total increments on every op 1. br_taken increments on taken op 1, including misaligned ones.

## Timing
- Reset (rst_n low, async): state IDLE, in_ready=1, redir_valid=0, redir_pc=0, flush=0, misalign=0, both counters 0. Any pending redirect or flush is abandoned immediately.
- Accept edge to redir_valid=1: 1 cycle. Outputs are registered.
- redir_valid stays high until the cycle redir_ready is sampled high. Dropping redir_ready has no effect on the held request.
- flush is high for exactly FLUSH_CYCLES cycles, starting the cycle after the redirect handshake.
- in_ready is low from the cycle after a taken accept until the cycle after flush ends, so the next accept is possible 1 cycle after the last flush cycle.
- Throughput:
  - Not-taken ops, op 0, and misaligned ops: 1 per cycle.
  - Taken op with redir_ready tied high: one per 2+FLUSH_CYCLES cycles.
- misalign is asserted in the cycle after the accept edge.
- Changes on in_* while in_ready=0 are ignored.

## Test plan
- Reset mid-REDIRECT: force rst_n low while redir_valid=1 → all outputs at their reset values within the same cycle, in_ready=1 after release.
- Back-to-back not-taken: op 1 with Compare_Result=0 on 5 consecutive cycles → in_ready stays 1, redir_valid stays 0, br_total=5, br_taken=0.
- Taken branch: in_pc=0x8000_0000, in_imm=0xFFFF_FFFF_FFFF_FFF0, Compare_Result all-ones, redir_ready=1 → next cycle redir_valid=1 with redir_pc=0x7FFF_FFF0, then flush high for 2 cycles, then in_ready=1.
- Backpressure: JAL with redir_ready=0 for 4 cycles → redir_valid and redir_pc held for 4 cycles, flush=0 and in_ready=0 throughout; on redir_ready=1, the flush sequence starts.
- JALR: in_rs1=0x8000_0103, in_imm=4 → redir_pc=0x8000_0106 (bit0 cleared) with bit1 set → misalign pulse, no redirect, in_ready stays 1. Repeat with in_rs1=0x8000_0101 → redir_pc=0x8000_0104, normal redirect.
- Saturation and wrap: CNT_W=4 with 20 taken branches → br_total and br_taken stick at 15. Also in_pc=0xFFFF_FFFF_FFFF_FFFC with imm=8 → redir_pc=0x4.
